// File: rtl/regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_queue
// Purpose  : In-order write-back FIFO in front of the 8x16 register file,
//            with youngest-entry forwarding on two lookup ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [AW-1:0]              res_addr,
    input  logic [DW-1:0]              res_data,
    input  logic                       hold,
    output logic                       rf_write,
    output logic [AW-1:0]              rf_write_addr,
    output logic [DW-1:0]              rf_write_data,
    input  logic [AW-1:0]              q1_addr,
    output logic                       q1_hit,
    output logic [DW-1:0]              q1_data,
    input  logic [AW-1:0]              q2_addr,
    output logic                       q2_hit,
    output logic [DW-1:0]              q2_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       idle,
    output logic                       err_addr
);

    localparam int PW       = $clog2(DEPTH);
    localparam int NUM_REGS = 8;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          head_bad;
    logic [PW-1:0] idx;

    // Addresses beyond the register file occupy a slot but are never written or forwarded.
    function automatic logic is_bad(input logic [AW-1:0] a);
        return int'(a) >= NUM_REGS;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign res_ready = !full;
    assign push      = res_valid && !full;
    assign pop       = !empty && !hold;
    assign head_bad  = is_bad(addr_mem[rd_ptr]);

    assign rf_write      = pop && !head_bad;
    assign rf_write_addr = rf_write ? addr_mem[rd_ptr] : '0;
    assign rf_write_data = rf_write ? data_mem[rd_ptr] : '0;
    assign pending       = count;
    assign idle          = empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            err_addr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (is_bad(res_addr)) begin
                    err_addr <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= res_addr;
            data_mem[wr_ptr] <= res_data;
        end
    end

    // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
    always_comb begin
        q1_hit  = 1'b0;
        q1_data = '0;
        q2_hit  = 1'b0;
        q2_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && !is_bad(addr_mem[idx])) begin
                if (addr_mem[idx] == q1_addr) begin
                    q1_hit  = 1'b1;
                    q1_data = data_mem[idx];
                end
                if (addr_mem[idx] == q2_addr) begin
                    q2_hit  = 1'b1;
                    q2_data = data_mem[idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_queue
// Purpose  : Directed and random checking of the write-back queue against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clock;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_addr;
    logic [15:0] res_data;
    logic        hold;
    logic        rf_write;
    logic [3:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic [3:0]  q1_addr;
    logic        q1_hit;
    logic [15:0] q1_data;
    logic [3:0]  q2_addr;
    logic        q2_hit;
    logic [15:0] q2_data;
    logic [2:0]  pending;
    logic        idle;
    logic        err_addr;

    ent_t mq[$];
    logic m_err;
    int   n_checks;
    int   n_fail;

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(4), .DW(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_addr      (res_addr),
        .res_data      (res_data),
        .hold          (hold),
        .rf_write      (rf_write),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .q1_addr       (q1_addr),
        .q1_hit        (q1_hit),
        .q1_data       (q1_data),
        .q2_addr       (q2_addr),
        .q2_hit        (q2_hit),
        .q2_data       (q2_data),
        .pending       (pending),
        .idle          (idle),
        .err_addr      (err_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest queued entry with a legal matching address.
    task automatic fwd(input logic [3:0] qa, output logic hit, output logic [15:0] data);
        hit  = 1'b0;
        data = 16'h0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == qa && mq[i].a < 4'd8) begin
                hit  = 1'b1;
                data = mq[i].d;
                break;
            end
        end
    endtask

    task automatic check_all();
        logic        e_wr;
        logic [3:0]  e_wa;
        logic [15:0] e_wd;
        logic        h1, h2;
        logic [15:0] d1, d2;
        e_wr = (mq.size() > 0) && !hold && (mq[0].a < 4'd8);
        e_wa = e_wr ? mq[0].a : 4'h0;
        e_wd = e_wr ? mq[0].d : 16'h0;
        fwd(q1_addr, h1, d1);
        fwd(q2_addr, h2, d2);
        chk("res_ready", 32'(res_ready), 32'(mq.size() < DEPTH));
        chk("rf_write", 32'(rf_write), 32'(e_wr));
        chk("rf_write_addr", 32'(rf_write_addr), 32'(e_wa));
        chk("rf_write_data", 32'(rf_write_data), 32'(e_wd));
        chk("q1_hit", 32'(q1_hit), 32'(h1));
        chk("q1_data", 32'(q1_data), 32'(d1));
        chk("q2_hit", 32'(q2_hit), 32'(h2));
        chk("q2_data", 32'(q2_data), 32'(d2));
        chk("pending", 32'(pending), 32'(mq.size()));
        chk("idle", 32'(idle), 32'(mq.size() == 0));
        chk("err_addr", 32'(err_addr), 32'(m_err));
    endtask

    // One clock cycle: apply inputs, check outputs before the edge, advance the model.
    task automatic cyc(input logic v, input logic [3:0] a, input logic [15:0] d, input logic h);
        logic do_pop, do_push;
        res_valid = v;
        res_addr  = a;
        res_data  = d;
        hold      = h;
        #1;
        if (!reset) check_all();
        do_pop  = (mq.size() > 0) && !h;
        do_push = v && (mq.size() < DEPTH);
        @(posedge clock);
        if (reset) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{a: a, d: d});
                if (a >= 4'd8) m_err = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_err     = 1'b0;
        reset     = 1'b1;
        res_valid = 1'b0;
        res_addr  = 4'h0;
        res_data  = 16'h0;
        hold      = 1'b0;
        q1_addr   = 4'h0;
        q2_addr   = 4'h0;
        @(posedge clock);
        #1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0);

        // Basic single write with one-cycle latency.
        q1_addr = 4'd3;
        q2_addr = 4'd4;
        cyc(1, 4'd3, 16'h1234, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Fill under hold, refused fifth offer, ordered drain.
        for (int i = 0; i < 4; i++) cyc(1, 4'(i), 16'hA000 + 16'(i), 1);
        cyc(1, 4'd7, 16'hDEAD, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);

        // Forwarding: youngest match wins, non-matching port reads zero.
        q1_addr = 4'd5;
        q2_addr = 4'd6;
        cyc(1, 4'd5, 16'hAAAA, 1);
        cyc(1, 4'd5, 16'hBBBB, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Simultaneous push/pop at count 2, then wrap-around.
        cyc(1, 4'd1, 16'h0101, 1);
        cyc(1, 4'd2, 16'h0202, 1);
        cyc(1, 4'd3, 16'h0303, 0);
        for (int i = 0; i < 10; i++) cyc(1, 4'(i % 8), 16'h5000 + 16'(i), 1'(i % 3 == 0));
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

        // Illegal address: accepted, drained silently, sticky error.
        q1_addr = 4'd9;
        cyc(1, 4'd9, 16'hFFFF, 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Reset with three queued entries discards them and clears the error.
        cyc(1, 4'd1, 16'h1111, 1);
        cyc(1, 4'd2, 16'h2222, 1);
        cyc(1, 4'd3, 16'h3333, 1);
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ra;
            ra      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            q1_addr = 4'($urandom_range(0, 9));
            q2_addr = 4'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 3) != 0), ra, 16'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
